regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with a per-register scoreboard of pending writes.
- Sits between decode and writeback in the pipelined RISC-V core.
- Decode reads operands and sees which sources are still awaiting a result (hazard/stall).
- Writeback commits results and clears the pending state.
- Successor to the single-cycle two-read register file: generalised in width, depth and read-port count, and adds scoreboard tracking, flush and optional write-through bypass.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREGS), address width; derived, not overridden.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 register 0 is hardwired to zero and never busy; if 0 it is a normal register.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational from rd_addr.
- rd_busy  out  NRD  per-port: addressed register has a pending write.
- hazard  out  1  OR of rd_busy across ports whose rd_en is high.
- rd_en  in  NRD  per-port: source is actually used this cycle.
- iss_valid  in  1  an instruction with a destination is issuing.
- iss_rd  in  AW  destination register of the issuing instruction.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  pipeline flush: clear all busy bits.
- busy_vec  out  NREGS  current scoreboard, for debug/perf.

Behaviour:
- Reset (rst_n low, asynchronous): all registers become 0 and all busy bits become 0.
  - While in reset: rd_data = 0, rd_busy = 0, hazard = 0, busy_vec = 0.
  - Reset asserted mid-operation discards any pending writes immediately.
  - Release takes effect on the first rising clk with rst_n high.
- Register write: on posedge clk, if wb_valid, regs[wb_rd] <= wb_data.
  - When ZERO_REG = 1, writes to address 0 are ignored.
- Register read: rd_data[k] = regs[rd_addr[k]], combinational, zero added latency.
  - When ZERO_REG = 1, address 0 always reads 0.
- Scoreboard update, per register r, at posedge clk, evaluated in this priority order:
  1. flush: busy[r] <= 0 for all r. flush wins over a same-cycle iss_valid; writeback data still commits.
  2. iss_valid && iss_rd == r: busy[r] <= 1. Issue wins over a same-cycle wb to the same r, because the new producer is outstanding.
  3. wb_valid && wb_rd == r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Register 0 busy bit is constant 0 when ZERO_REG = 1.
- Writeback to a non-busy register is legal: data commits and busy stays 0.
- Scoreboard is single-bit: one outstanding producer per register. A second issue to a busy register keeps it busy, and the first writeback clears it.
- rd_busy[k] = busy[rd_addr[k]], as registered state (no bypass applied); see Optional Feature.
- hazard = |(rd_busy & rd_en).
- Out-of-range addresses cannot occur (AW is exact).
- Multiple read ports addressing the same register return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If wb_valid && wb_rd == rd_addr[k] (and not the zero register), rd_data[k] = wb_data in the same cycle.
  - rd_busy[k] = 0 for that port unless iss_valid && iss_rd == rd_addr[k] in the same cycle.
- Undefined:
  - Read data reflects the value only from the cycle after the write.
  - rd_busy reflects registered busy only, so a same-cycle writeback still reports busy and raises hazard.

Decomposition:
- Package regfile_pkg:
  - default XLEN/NREGS constants;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef xdata_t (logic [XLEN-1:0]);
  - localparam ZERO_ADDR.
- One sub-module: regfile_scoreboard (busy vector, flush/issue/wb priority, busy_vec output).
- Storage and read muxing stay in the top level.

Test Plan:
- Reset then read: rst_n low 3 cycles, release; rd_addr = {5, 0} -> rd_data = {0, 0}, busy_vec = 0, hazard = 0.
- Write/read: wb x7 = 0xDEADBEEF; next cycle rd_addr[0] = 7 -> 0xDEADBEEF. wb x0 = 0x1234 -> x0 reads 0, busy_vec[0] = 0.
- Scoreboard: issue x3.
  - Next cycle: rd_addr[1] = 3, rd_en = 2'b10 -> rd_busy[1] = 1, hazard = 1.
  - With rd_en = 0: hazard = 0.
  - wb x3 = 0x55 -> next cycle busy clear, data 0x55.
- Collision: same cycle issue x4 and wb x4 = 0x99 -> busy[4] = 1 after the edge, regs[4] = 0x99. Same cycle flush and issue x4 -> busy_vec = 0.
- Async reset mid-op: busy {x1, x2} set and x9 = 0xA5; drop rst_n between edges -> busy_vec and rd_data go 0 immediately, without waiting for a clock.
- Bypass: wb x6 = 0x42 with rd_addr[0] = 6 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data[0] = 0x42, rd_busy[0] = 0.
  - Without it: old value, and rd_busy[0] = 1 if x6 was busy.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and types for the scoreboarded integer register file.
// Consumers: regfile_sb, regfile_sb_if, regfile_scoreboard.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);
   localparam int ZERO_ADDR = 0;

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file; master = pipeline, slave = regfile.
// Read data and busy flags are combinational from the addresses; no handshake.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NRD-1:0]      rd_en;
   logic                hazard;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                wb_valid;
   logic [AW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                flush;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_addr, rd_en, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
      input  rd_data, rd_busy, hazard, busy_vec
   );

   modport slave (
      input  rd_addr, rd_en, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
      output rd_data, rd_busy, hazard, busy_vec
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write bits: flush > issue > writeback > hold.
// Updates on the clock edge; busy is visible the cycle after issue.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     iss_valid,
   input  logic [$clog2(NREGS)-1:0] iss_rd,
   input  logic                     wb_valid,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic                     flush,
   output logic [NREGS-1:0]         busy
);
   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0] busy_nxt;

   // Issue beats a same-cycle writeback: the new producer is still outstanding.
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < NREGS; r++) begin
         if (flush) begin
            busy_nxt[r] = 1'b0;
         end else if (iss_valid && (iss_rd == AW'(r))) begin
            busy_nxt[r] = 1'b1;
         end else if (wb_valid && (wb_rd == AW'(r))) begin
            busy_nxt[r] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         busy_nxt[ZERO_ADDR] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard; reads are zero-latency.
// Optional same-cycle writeback forwarding under `REGFILE_BYPASS_EN.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_sb_if.slave   bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]     regs [NREGS];
   logic [NREGS-1:0]    busy;
   logic [NRD*XLEN-1:0] rd_data_w;
   logic [NRD-1:0]      rd_busy_w;
   logic                wb_to_zero;

   assign wb_to_zero = (ZERO_REG != 0) && (bus.wb_rd == AW'(ZERO_ADDR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (bus.wb_valid && !wb_to_zero) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .wb_valid  (bus.wb_valid),
      .wb_rd     (bus.wb_rd),
      .flush     (bus.flush),
      .busy      (busy)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;

      assign addr    = bus.rd_addr[k*AW +: AW];
      assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_ADDR));

`ifdef REGFILE_BYPASS_EN
      logic byp_hit;

      // Forwarding is gated by reset so outputs stay quiet while rst_n is low.
      assign byp_hit = rst_n && bus.wb_valid && (bus.wb_rd == addr) && !is_zero;
      assign rd_data_w[k*XLEN +: XLEN] = is_zero ? '0 :
                                         byp_hit ? bus.wb_data : regs[addr];
      assign rd_busy_w[k] = byp_hit ? (bus.iss_valid && (bus.iss_rd == addr)) : busy[addr];
`else
      assign rd_data_w[k*XLEN +: XLEN] = is_zero ? '0 : regs[addr];
      assign rd_busy_w[k] = busy[addr];
`endif
   end

   assign bus.rd_data  = rd_data_w;
   assign bus.rd_busy  = rd_busy_w;
   assign bus.hazard   = |(rd_busy_w & bus.rd_en);
   assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

   regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // reference state
   xdata_t m_regs [32];
   bit     m_busy [32];

   // stimulus state
   reg_addr_t a [2];
   logic [1:0] en;
   logic       iv, wv, fl;
   reg_addr_t  ird, wrd;
   xdata_t     wdat;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   function automatic bit byp(input reg_addr_t ad);
`ifdef REGFILE_BYPASS_EN
      return rst_n && wv && (wrd == ad) && (ad != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic xdata_t exp_data(input reg_addr_t ad);
      if (ad == 0) return '0;
      if (byp(ad)) return wdat;
      return m_regs[ad];
   endfunction

   function automatic bit exp_busy(input reg_addr_t ad);
      if (byp(ad)) return iv && (ird == ad);
      return m_busy[ad];
   endfunction

   task automatic apply();
      bus.rd_addr   = {a[1], a[0]};
      bus.rd_en     = en;
      bus.iss_valid = iv;
      bus.iss_rd    = ird;
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.wb_data   = wdat;
      bus.flush     = fl;
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] bv;
      logic        hz;
      hz = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.data%0d", tag, k), bus.rd_data[k*32 +: 32], exp_data(a[k]));
         chk($sformatf("%s.busy%0d", tag, k), {31'b0, bus.rd_busy[k]}, {31'b0, exp_busy(a[k])});
         hz = hz | (exp_busy(a[k]) & en[k]);
      end
      chk($sformatf("%s.hazard", tag), {31'b0, bus.hazard}, {31'b0, hz});
      for (int r = 0; r < 32; r++) bv[r] = m_busy[r];
      chk($sformatf("%s.busy_vec", tag), bus.busy_vec, bv);
   endtask

   // State changes the DUT should make at a rising edge, stated rule by rule.
   task automatic commit();
      if (wv && wrd != 0) m_regs[wrd] = wdat;
      if (fl) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else begin
         if (wv) m_busy[wrd] = 1'b0;
         if (iv) m_busy[ird] = 1'b1;
      end
      m_busy[0] = 1'b0;
   endtask

   task automatic tick(input string tag);
      apply();
      #3;
      check_outputs(tag);
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic idle();
      iv = 1'b0; wv = 1'b0; fl = 1'b0;
   endtask

   initial begin
      a[0] = '0; a[1] = '0; en = '0; ird = '0; wrd = '0; wdat = '0;
      idle();
      model_reset();
      apply();

      // reset held three cycles, outputs must be quiet
      repeat (3) @(posedge clk);
      #1;
      a[1] = 5'd5; a[0] = 5'd0; en = 2'b11;
      apply();
      #1;
      check_outputs("in_reset");
      rst_n = 1'b1;
      tick("release");

      // write / read, including the hardwired zero register
      en = 2'b00;
      wv = 1'b1; wrd = 5'd7; wdat = 32'hDEADBEEF; tick("wb7");
      idle(); a[0] = 5'd7; tick("rd7");
      chk("x7_const", bus.rd_data[31:0], 32'hDEADBEEF);
      wv = 1'b1; wrd = 5'd0; wdat = 32'h1234; a[0] = 5'd0; tick("wb0");
      idle(); tick("rd0");
      chk("x0_const", bus.rd_data[31:0], 32'h0);

      // scoreboard issue / hazard / writeback
      iv = 1'b1; ird = 5'd3; tick("iss3");
      idle(); a[1] = 5'd3; en = 2'b10; tick("busy3");
      en = 2'b00; tick("nohz3");
      wv = 1'b1; wrd = 5'd3; wdat = 32'h55; en = 2'b10; tick("wb3");
      idle(); tick("rd3");

      // same-cycle collisions
      iv = 1'b1; ird = 5'd4; wv = 1'b1; wrd = 5'd4; wdat = 32'h99; a[0] = 5'd4; en = 2'b01;
      tick("col4");
      idle(); tick("col4_after");
      fl = 1'b1; iv = 1'b1; ird = 5'd4; tick("flush4");
      idle(); tick("flush4_after");

      // same-cycle writeback seen by a reader (forwarded only in bypass builds)
      iv = 1'b1; ird = 5'd6; tick("iss6");
      idle(); wv = 1'b1; wrd = 5'd6; wdat = 32'h42; a[0] = 5'd6; en = 2'b01; tick("byp6");
      idle(); tick("byp6_after");
      a[1] = 5'd6; tick("dual6");

      // asynchronous reset between edges
      iv = 1'b1; ird = 5'd1; tick("iss1");
      ird = 5'd2; wv = 1'b1; wrd = 5'd9; wdat = 32'hA5; tick("iss2_wb9");
      idle(); a[1] = 5'd9; a[0] = 5'd1; en = 2'b11; tick("pre_arst");
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("arst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("post_arst");

      // random traffic, addresses biased low so collisions are frequent
      for (int i = 0; i < 400; i++) begin
         a[0] = reg_addr_t'($urandom_range(0, 7));
         a[1] = ($urandom_range(0, 3) == 0) ? a[0] : reg_addr_t'($urandom_range(0, 31));
         en   = 2'($urandom_range(0, 3));
         iv   = 1'($urandom_range(0, 1));
         ird  = reg_addr_t'($urandom_range(0, 7));
         wv   = 1'($urandom_range(0, 1));
         wrd  = reg_addr_t'($urandom_range(0, 7));
         wdat = $urandom;
         fl   = ($urandom_range(0, 15) == 0);
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
